vga_mem_arbiter: RTL and testbench
==================================

// Module: vga_mem_arbiter
// PURPOSE
//   Owns the single synchronous-read memory port shared by the VGA text engine and the CPU.
//   - Runs a free 8-slot round and exports the slot count acnt to the VGA controller.
//   - Slot 0 is reserved for the VGA frame-buffer read, slot 1 for the VGA glyph-ROM read.
//   - Slots 2..7 serve CPU read/write requests through a req/gnt/rvalid handshake.
//   - Captures the VGA return data and holds it steady for the rest of the round.
// PARAMETERS
//   AW        16      memory address width
//   DW        16      memory data width (= `DATAWIDTH)
//   ROM_BASE  16'h0000+`ROM_SIZE   first write-protected address; CPU writes at or above it are dropped
//   CPU_MAX   6       max CPU grants per round (1..6)
// PORTS
//   clk              in   1   system clock
//   rst              in   1   synchronous, active-low reset
//   acnt             out  3   slot counter 0..7, wraps 7->0
//   vga_addr         in   AW  VGA address (FB addr in slot 0, glyph addr in slot 1)
//   vga_glyph_num    out  DW  frame-buffer word for the current cell
//   vga_glyph_pixels out  DW  glyph-row word for the current cell
//   cpu_req          in   1   CPU request; held until cpu_gnt
//   cpu_we           in   1   1=write, 0=read; valid with cpu_req
//   cpu_addr         in   AW  CPU address
//   cpu_wdata        in   DW  CPU write data
//   cpu_gnt          out  1   1-cycle pulse: access issued this cycle
//   cpu_rvalid       out  1   1-cycle pulse: cpu_rdata valid
//   cpu_rdata        out  DW  registered read data, held until next read
//   cpu_err          out  1   1-cycle pulse: protected write dropped
//   mem_en           out  1   memory access enable
//   mem_we           out  1   memory write enable
//   mem_addr         out  AW  memory address
//   mem_wdata        out  DW  memory write data
//   mem_rdata        in   DW  memory read data, valid the cycle after the access
// BEHAVIOUR
//   Reset (rst=0 at posedge)
//   - acnt, all registers and all outputs go to 0; CPU FSM goes to IDLE.
//   - While rst=0, mem_en/mem_we/mem_addr are forced to 0 combinationally.
//   - An in-flight CPU read is abandoned: no rvalid is issued and the CPU must re-request.
//   Slot counter
//   - acnt increments every clk, 7->0 wrap; a round is 8 cycles.
//   - The grant counter gcnt clears when acnt wraps to 0.
//   Memory mux (combinational on acnt)
//   - Slot 0: mem_en=1, mem_we=0, mem_addr=vga_addr.
//   - Slot 1: mem_en=1, mem_we=0, mem_addr=vga_addr.
//   - Slots 2..7: CPU access on grant; otherwise mem_en=0, mem_we=0, mem_addr=0.
//   VGA data
//   - In slot 1, vga_glyph_num = mem_rdata (bypass) and is registered at the slot-1 edge.
//   - In all other slots, vga_glyph_num is the held register value.
//   - vga_glyph_pixels is registered from mem_rdata at the slot-2 edge and held through slot 1.
//   CPU FSM: IDLE -> RD_DATA -> RD_RESP -> IDLE
//   - grant = cpu_req & state==IDLE & acnt>=2 & gcnt<CPU_MAX.
//   - On grant: cpu_gnt=1 the same cycle, mem_addr=cpu_addr, gcnt++.
//   - Grant read: mem_en=1, mem_we=0; next state RD_DATA.
//   - RD_DATA: cpu_rdata <= mem_rdata; next state RD_RESP.
//   - RD_RESP: cpu_rvalid=1; next state IDLE; no grant this cycle.
//   - Read latency: grant at N, rvalid at N+2.
//   - Grant write, cpu_addr<ROM_BASE: mem_en=1, mem_we=1, mem_wdata=cpu_wdata; stay IDLE (back-to-back OK).
//   - Grant write, cpu_addr>=ROM_BASE: mem_en=0, cpu_gnt=1, cpu_err=1 at N+1.
//   - A read granted in slot 7 returns its data in slot 0; it does not disturb VGA capture.
//   - cpu_req in slots 0/1, or with gcnt==CPU_MAX, waits for the next eligible slot.
// TESTING
//   1. Reset release: acnt counts 0..7,0; mem_en=1 only in slots 0/1 with cpu_req=0; all CPU outputs stay 0.
//   2. VGA capture: mem_rdata=16'h1234 in slot 1, 16'hABCD in slot 2
//      -> glyph_num=1234 and glyph_pixels=ABCD held through the next slot 1.
//   3. cpu_req held from slot 0 (write addr 16'h0100, data 16'h00FF)
//      -> gnt in slot 2, mem_we=1, addr 0100, data 00FF; no err.
//   4. Read granted in slot 7, mem_rdata=16'h5A5A in slot 0
//      -> cpu_rvalid in slot 1, cpu_rdata=5A5A; VGA glyph_num unaffected.
//   5. Write to ROM_BASE -> gnt=1, mem_en=0, cpu_err pulses next cycle.
//      CPU_MAX=2 with req held: exactly 2 gnts per round (slots 2,3).
//   6. rst=0 in RD_DATA -> no rvalid; acnt=0, all outputs 0; after release, a re-request is granted from slot 2.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Shared synchronous-read memory port arbiter: fixed VGA slots 0/1 in an
// 8-slot round, CPU read/write service with a bounded grant count in slots 2..7.
module vga_mem_arbiter #(
  parameter int              AW       = 16,
  parameter int              DW       = 16,
  parameter logic [AW-1:0]   ROM_BASE = 16'h8000,
  parameter int              CPU_MAX  = 6
) (
  input  logic          clk,
  input  logic          rst,
  output logic [2:0]    acnt,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_glyph_num,
  output logic [DW-1:0] vga_glyph_pixels,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    RD_RESP = 2'd2
  } state_t;

  localparam logic [2:0] CPU_MAX_C = 3'(CPU_MAX);

  logic [2:0]    acnt_r;
  logic [2:0]    gcnt_r;
  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] glyph_num_r;
  logic [DW-1:0] glyph_pix_r;
  logic [DW-1:0] cpu_rdata_r;
  logic          err_r;
  logic          grant_s;
  logic          prot_s;

  assign prot_s  = (cpu_addr >= ROM_BASE);
  assign grant_s = rst & cpu_req & (state_r == IDLE) & (acnt_r >= 3'd2) & (gcnt_r < CPU_MAX_C);

  // Slot counter and per-round grant counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      acnt_r <= 3'd0;
      gcnt_r <= 3'd0;
    end else begin
      acnt_r <= acnt_r + 3'd1;
      if (acnt_r == 3'd7) begin
        gcnt_r <= 3'd0;
      end else if (grant_s) begin
        gcnt_r <= gcnt_r + 3'd1;
      end else begin
        gcnt_r <= gcnt_r;
      end
    end
  end

  // VGA capture: FB word returns in slot 1, glyph row returns in slot 2
  always_ff @(posedge clk) begin
    if (!rst) begin
      glyph_num_r <= '0;
      glyph_pix_r <= '0;
    end else begin
      if (acnt_r == 3'd1) begin
        glyph_num_r <= mem_rdata;
      end
      if (acnt_r == 3'd2) begin
        glyph_pix_r <= mem_rdata;
      end
    end
  end

  // CPU read data capture and protected-write error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rdata_r <= '0;
      err_r       <= 1'b0;
    end else begin
      if (state_r == RD_DATA) begin
        cpu_rdata_r <= mem_rdata;
      end
      err_r <= grant_s & cpu_we & prot_s;
    end
  end

  // CPU FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // CPU FSM next-state logic; writes never leave IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s && !cpu_we) begin
          state_s = RD_DATA;
        end else begin
          state_s = IDLE;
        end
      end
      RD_DATA: state_s = RD_RESP;
      RD_RESP: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory port mux and CPU handshake outputs
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_gnt    = grant_s;
    cpu_rvalid = (state_r == RD_RESP);
    if (!rst) begin
      mem_en   = 1'b0;
      mem_addr = '0;
    end else if (acnt_r <= 3'd1) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
    end else if (grant_s) begin
      mem_addr = cpu_addr;
      if (!cpu_we) begin
        mem_en = 1'b1;
      end else if (!prot_s) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = cpu_wdata;
      end else begin
        mem_en = 1'b0;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Slot-1 bypass lets the controller use the FB word in the cycle it arrives
  assign vga_glyph_num    = (rst && acnt_r == 3'd1) ? mem_rdata : glyph_num_r;
  assign vga_glyph_pixels = glyph_pix_r;
  assign acnt             = acnt_r;
  assign cpu_rdata        = cpu_rdata_r;
  assign cpu_err          = err_r;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: stimulus pushes expected grants,
// read responses and errors; a negedge monitor pops and compares them.
module tb_vga_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  acnt;
  logic [15:0] vga_addr;
  logic [15:0] vga_glyph_num;
  logic [15:0] vga_glyph_pixels;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  vga_mem_arbiter #(.AW(16), .DW(16), .ROM_BASE(16'h8000), .CPU_MAX(2)) dut (
    .clk(clk), .rst(rst), .acnt(acnt), .vga_addr(vga_addr),
    .vga_glyph_num(vga_glyph_num), .vga_glyph_pixels(vga_glyph_pixels),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        en;
    logic [2:0]  slot;
    bit          prot;
  } gnt_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  slot;
  } rv_t;

  gnt_t       gnt_q[$];
  rv_t        rv_q[$];
  logic [2:0] err_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_acnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference slot counter
  always @(posedge clk) exp_acnt <= rst ? exp_acnt + 3'd1 : 3'd0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: slot counter every cycle, plus scoreboard pops on each handshake pulse
  initial begin
    gnt_t g;
    rv_t  r;
    logic [2:0] es;
    forever begin
      @(negedge clk);
      chk("acnt", 32'(acnt), 32'(exp_acnt));
      if (cpu_gnt === 1'b1) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", 32'(acnt), 32'hFFFF_FFFF);
        end else begin
          g = gnt_q.pop_front();
          chk("gnt_slot", 32'(acnt), 32'(g.slot));
          chk("gnt_mem_en", 32'(mem_en), 32'(g.en));
          chk("gnt_mem_we", 32'(mem_we), 32'(g.we));
          if (!g.prot) begin
            chk("gnt_mem_addr", 32'(mem_addr), 32'(g.addr));
            if (g.we) chk("gnt_mem_wdata", 32'(mem_wdata), 32'(g.wdata));
          end
        end
      end
      if (cpu_rvalid === 1'b1) begin
        if (rv_q.size() == 0) begin
          chk("unexpected_rvalid", 32'(acnt), 32'hFFFF_FFFF);
        end else begin
          r = rv_q.pop_front();
          chk("rvalid_slot", 32'(acnt), 32'(r.slot));
          chk("rvalid_rdata", 32'(cpu_rdata), 32'(r.data));
        end
      end
      if (cpu_err === 1'b1) begin
        if (err_q.size() == 0) begin
          chk("unexpected_err", 32'(acnt), 32'hFFFF_FFFF);
        end else begin
          es = err_q.pop_front();
          chk("err_slot", 32'(acnt), 32'(es));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input logic [2:0] s);
    for (int i = 0; i < 16; i++) begin
      if (exp_acnt == s) break;
      tick();
    end
  endtask

  // Waits (bounded) for a grant, then drops the request after that edge
  task automatic wait_gnt(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (cpu_gnt === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 32'(got), 32'd1);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic push_gnt(input logic [15:0] a, input logic [15:0] d, input logic we,
                          input logic en, input logic [2:0] s, input bit p);
    gnt_t g;
    g.addr = a; g.wdata = d; g.we = we; g.en = en; g.slot = s; g.prot = p;
    gnt_q.push_back(g);
  endtask

  task automatic push_rv(input logic [15:0] d, input logic [2:0] s);
    rv_t r;
    r.data = d; r.slot = s;
    rv_q.push_back(r);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_err"}, 32'(cpu_err), 32'd0);
    chk({tag, "_gnt"}, 32'(cpu_gnt), 32'd0);
    chk({tag, "_glyph_num"}, 32'(vga_glyph_num), 32'd0);
    chk({tag, "_glyph_pix"}, 32'(vga_glyph_pixels), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
    cpu_wdata = 16'h0000; vga_addr = 16'h0000; mem_rdata = 16'h0000;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_acnt", 32'(acnt), 32'd0);
    chk_all_zero("rst");
    rst = 1'b1;

    // 1: free-running round, VGA-only memory access
    for (int i = 0; i < 9; i++) begin
      vga_addr = 16'h1000 + 16'(i);
      @(negedge clk);
      chk("t1_mem_en", 32'(mem_en), (exp_acnt <= 3'd1) ? 32'd1 : 32'd0);
      chk("t1_mem_addr", 32'(mem_addr), (exp_acnt <= 3'd1) ? 32'(vga_addr) : 32'd0);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      chk("t1_cpu_outs", 32'({cpu_gnt, cpu_rvalid, cpu_err}), 32'd0);
      tick();
    end

    // 2: VGA capture and hold
    wait_slot(3'd1);
    mem_rdata = 16'h1234;
    @(negedge clk);
    chk("t2_bypass", 32'(vga_glyph_num), 32'h1234);
    tick();
    mem_rdata = 16'hABCD;
    tick();
    mem_rdata = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_hold_num", 32'(vga_glyph_num), 32'h1234);
      chk("t2_hold_pix", 32'(vga_glyph_pixels), 32'hABCD);
      tick();
    end
    mem_rdata = 16'h1111;
    @(negedge clk);
    chk("t2_slot1_pix", 32'(vga_glyph_pixels), 32'hABCD);
    tick();
    mem_rdata = 16'h0000;

    // 3: write requested in slot 0 is granted in slot 2
    wait_slot(3'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h00FF;
    push_gnt(16'h0100, 16'h00FF, 1'b1, 1'b1, 3'd2, 1'b0);
    wait_gnt("t3_gnt_seen");

    // 4: read granted in slot 7 returns in slot 0, rvalid in slot 1
    wait_slot(3'd7);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    push_gnt(16'h0200, 16'h0000, 1'b0, 1'b1, 3'd7, 1'b0);
    push_rv(16'h5A5A, 3'd1);
    wait_gnt("t4_gnt_seen");
    mem_rdata = 16'h5A5A;
    tick();
    mem_rdata = 16'h2468;
    tick();
    mem_rdata = 16'h0000;
    tick();
    @(negedge clk);
    chk("t4_glyph_num", 32'(vga_glyph_num), 32'h2468);
    chk("t4_glyph_pix", 32'(vga_glyph_pixels), 32'h0000);
    chk("t4_rdata_held", 32'(cpu_rdata), 32'h5A5A);

    // 5a: protected write is dropped and flagged
    wait_slot(3'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 16'hBEEF;
    push_gnt(16'h8000, 16'hBEEF, 1'b0, 1'b0, 3'd2, 1'b1);
    err_q.push_back(3'd3);
    wait_gnt("t5a_gnt_seen");

    // 5b: request held a full round, capped at two grants
    wait_slot(3'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h0001;
    push_gnt(16'h0010, 16'h0001, 1'b1, 1'b1, 3'd2, 1'b0);
    push_gnt(16'h0010, 16'h0001, 1'b1, 1'b1, 3'd3, 1'b0);
    repeat (8) tick();
    cpu_req = 1'b0;

    // 6: reset during RD_DATA abandons the read
    wait_slot(3'd3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    push_gnt(16'h0300, 16'h0000, 1'b0, 1'b1, 3'd3, 1'b0);
    wait_gnt("t6_gnt_seen");
    rst = 1'b0;
    mem_rdata = 16'h7777;
    @(negedge clk);
    chk("t6_forced_en", 32'(mem_en), 32'd0);
    chk("t6_forced_addr", 32'(mem_addr), 32'd0);
    tick();
    mem_rdata = 16'h0000;
    @(negedge clk);
    chk("t6_acnt", 32'(acnt), 32'd0);
    chk_all_zero("t6");
    tick();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    push_gnt(16'h0400, 16'h0000, 1'b0, 1'b1, 3'd2, 1'b0);
    push_rv(16'hC0DE, 3'd4);
    wait_gnt("t6_regnt_seen");
    mem_rdata = 16'hC0DE;
    tick();
    mem_rdata = 16'h0000;
    repeat (4) tick();

    chk("end_gnt_q", 32'(gnt_q.size()), 32'd0);
    chk("end_rv_q", 32'(rv_q.size()), 32'd0);
    chk("end_err_q", 32'(err_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
